// File: rtl/interp_scan_counter_pkg.sv
// Shared types and constants for the HEVC interpolation scan counter.
// Compile-time option HEVC_TAP_MARGIN_EN widens the scan by the 8-tap filter footprint.
package hevc_interp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TAP_PRE  = 3;
  localparam int TAP_POST = 4;

`ifdef HEVC_TAP_MARGIN_EN
  // Scan runs -TAP_PRE .. size-1+TAP_POST on each axis.
  localparam int C0      = -TAP_PRE;
  localparam int END_OFS = TAP_POST - 1;
`else
  localparam int C0      = 0;
  localparam int END_OFS = -1;
`endif

endpackage

// File: rtl/interp_scan_counter_axis_counter.sv
// One scan axis: loadable counter that returns to its load value after reaching end_val.
module axis_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] end_val,
  output logic [W-1:0] value,
  output logic         at_end
);

  assign at_end = (value == end_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= at_end ? load_val : value + 1'b1;
    end
  end

endmodule

// File: rtl/interp_scan_counter.sv
// Start/done controlled raster generator emitting (col,row) beats under valid/ready.
// Build option: HEVC_TAP_MARGIN_EN extends the scan to the 8-tap filter footprint.
module interp_scan_counter
  import hevc_interp_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] blk_w,
  input  logic [COORD_W-1:0] blk_h,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last,
  output logic [CNT_W-1:0]   lin_cnt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  // Handshake: a beat transfers on any edge where out_valid && out_ready;
  // while out_ready is low col/row/last/out_valid stay unchanged.

  state_t state_q, state_d;
  logic [COORD_W-1:0] blk_w_q, blk_h_q;
  logic [COORD_W-1:0] col_end, row_end;
  logic               load, clr, accept, col_at_end, row_at_end;

  assign col_end   = blk_w_q + COORD_W'(END_OFS);
  assign row_end   = blk_h_q + COORD_W'(END_OFS);
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state     = state_q;
  assign last      = out_valid && col_at_end && row_at_end;
  assign accept    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (blk_w != '0 && blk_h != '0) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            clr     = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN:     if (accept && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      blk_w_q <= '0;
      blk_h_q <= '0;
      lin_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        blk_w_q <= blk_w;
        blk_h_q <= blk_h;
      end
      if (load || clr) lin_cnt <= '0;
      else if (accept) lin_cnt <= lin_cnt + 1'b1;
    end
  end

  // The final beat does not advance the axes, so col/row keep the end position.
  axis_counter #(.W(COORD_W)) u_col (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .inc      (accept && !last),
    .load_val (COORD_W'(C0)),
    .end_val  (col_end),
    .value    (col),
    .at_end   (col_at_end)
  );

  axis_counter #(.W(COORD_W)) u_row (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .inc      (accept && !last && col_at_end),
    .load_val (COORD_W'(C0)),
    .end_val  (row_end),
    .value    (row),
    .at_end   (row_at_end)
  );

endmodule

// File: tb/tb_interp_scan_counter.sv
// Directed bench for interp_scan_counter: reset, full scans, stalls, empty blocks, mid-scan reset.
module tb_interp_scan_counter;

  localparam int CW = 8;
  localparam int NW = 16;
`ifdef HEVC_TAP_MARGIN_EN
  localparam int PRE   = 3;
  localparam int EXTRA = 7;
`else
  localparam int PRE   = 0;
  localparam int EXTRA = 0;
`endif

  logic          clk, reset, start, out_ready;
  logic [CW-1:0] blk_w, blk_h, col, row;
  logic          out_valid, last, busy, done;
  logic [NW-1:0] lin_cnt;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;

  interp_scan_counter #(.COORD_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .blk_w     (blk_w),
    .blk_h     (blk_h),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .col       (col),
    .row       (row),
    .last      (last),
    .lin_cnt   (lin_cnt),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_col"},   32'(col),       32'd0);
    check({tag, "_row"},   32'(row),       32'd0);
    check({tag, "_last"},  32'(last),      32'd0);
    check({tag, "_cnt"},   32'(lin_cnt),   32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_state"}, 32'(state),     32'd0);
  endtask

  function automatic logic [CW-1:0] exp_coord(input int idx);
    return CW'(idx - PRE);
  endfunction

  // Full scan with out_ready held high; pokes start and sizes while busy.
  task automatic run_scan(input int w, input int h, input string tag);
    int nc, n;
    nc = w + EXTRA;
    n  = nc * (h + EXTRA);
    @(negedge clk);
    blk_w = CW'(w); blk_h = CW'(h); start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; blk_w = CW'(w + 1); blk_h = CW'(h + 2);
      end
      if (i == 1) start = 1'b1;
      if (i == n - 1) start = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_col"},   32'(col),       32'(exp_coord(i % nc)));
      check({tag, "_row"},   32'(row),       32'(exp_coord(i / nc)));
      check({tag, "_last"},  32'(last),      32'(i == n - 1));
      check({tag, "_cnt"},   32'(lin_cnt),   32'(i));
      check({tag, "_done"},  32'(done),      32'd0);
    end
    @(negedge clk);
    check({tag, "_end_done"},  32'(done),      32'd1);
    check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_end_busy"},  32'(busy),      32'd1);
    check({tag, "_end_cnt"},   32'(lin_cnt),   32'(n));
    check({tag, "_end_col"},   32'(col),       32'(exp_coord(nc - 1)));
    check({tag, "_end_row"},   32'(row),       32'(exp_coord(h + EXTRA - 1)));
    @(negedge clk);
    check({tag, "_idle_done"},  32'(done),    32'd0);
    check({tag, "_idle_busy"},  32'(busy),    32'd0);
    check({tag, "_idle_state"}, 32'(state),   32'd0);
    check({tag, "_hold_cnt"},   32'(lin_cnt), 32'(n));
  endtask

  // Scan with out_ready alternating 1,0,...; outputs must hold while stalled.
  task automatic run_stall(input int w, input int h, input string tag);
    int nc, n, b, cyc;
    nc = w + EXTRA;
    n  = nc * (h + EXTRA);
    b = 0; cyc = 0;
    @(negedge clk);
    blk_w = CW'(w); blk_h = CW'(h); start = 1'b1; out_ready = 1'b0;
    while (b < n && cyc < 4 * n + 8) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_col"},   32'(col),       32'(exp_coord(b % nc)));
      check({tag, "_row"},   32'(row),       32'(exp_coord(b / nc)));
      check({tag, "_last"},  32'(last),      32'(b == n - 1));
      check({tag, "_cnt"},   32'(lin_cnt),   32'(b));
      out_ready = (cyc % 2 == 0);
      if (out_ready) b++;
      cyc++;
    end
    check({tag, "_beats"}, 32'(b), 32'(n));
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, "_end_done"},  32'(done),      32'd1);
    check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_end_cnt"},   32'(lin_cnt),   32'(n));
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_empty(input int w, input int h, input string tag);
    @(negedge clk);
    blk_w = CW'(w); blk_h = CW'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"},  32'(done),      32'd1);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_cnt"},   32'(lin_cnt),   32'd0);
    check({tag, "_busy"},  32'(busy),      32'd1);
    check({tag, "_state"}, 32'(state),     32'd2);
    @(negedge clk);
    check({tag, "_idle_done"},  32'(done),      32'd0);
    check({tag, "_idle_busy"},  32'(busy),      32'd0);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; blk_w = 8'd4; blk_h = 8'd2; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_zero("reset_released");

    run_scan(4, 2, "scan_4x2");
    run_stall(4, 2, "stall_4x2");
    run_empty(0, 5, "empty_w0");
    run_empty(3, 0, "empty_h0");
    run_scan(1, 1, "scan_1x1");
`ifdef HEVC_TAP_MARGIN_EN
    run_scan(4, 4, "margin_4x4");
`else
    run_scan(3, 3, "scan_3x3");
`endif

    // Reset in the middle of a scan, then a clean rescan.
    @(negedge clk);
    blk_w = 8'd4; blk_h = 8'd2; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("midrst_col", 32'(col), 32'(exp_coord(i)));
    end
    reset = 1'b1;
    #1;
    check_zero("midrst_async");
    @(negedge clk);
    check_zero("midrst_held");
    reset = 1'b0;
    @(negedge clk);
    check_zero("midrst_nodone");
    run_scan(4, 2, "rescan_4x2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interp_scan_counter.md
# interp_scan_counter

Parametrised 2-D scan counter for the HEVC subpixel interpolation datapath. It generalises the free-running pixel counter into a start/done-controlled raster generator with run-time block width and height. It emits one (col, row) coordinate per accepted beat under a valid/ready handshake, plus a linear beat count. It sits between the block scheduler and the reference-pixel fetch/filter pipeline, replacing the bare 8-bit counter.

## Interface
Parameters:
- COORD_W, 8: width of col/row outputs and blk_w/blk_h inputs; two's complement when margin is compiled in.
- CNT_W, 16: width of linear beat counter lin_cnt.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- blk_w  in  COORD_W  block width in pixels (unsigned, 1..2^COORD_W-1 usable)
- blk_h  in  COORD_W  block height in rows (unsigned)
- out_ready  in  1  downstream accepts current coordinate
- out_valid  out  1  col/row/last valid
- col  out  COORD_W  current column
- row  out  COORD_W  current row
- last  out  1  current beat is final position of the block
- lin_cnt  out  CNT_W  beats accepted since last start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of scan

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; all outputs 0.
- IDLE: on start=1 with blk_w!=0 and blk_h!=0: latch blk_w/blk_h, load col=row=C0 (C0=0, or -3 with margin), clear lin_cnt, go RUN.
- IDLE, start=1 with blk_w=0 or blk_h=0: no beats; go DONE (done pulse next cycle, lin_cnt cleared to 0).
- RUN: out_valid=1. Beat accepted when out_valid&&out_ready: lin_cnt+=1 (wraps mod 2^CNT_W); if col==col_end then col=C0, row+=1, else col+=1.
- col_end = W-1 (margin: W+3); row_end = H-1 (margin: H+3), from latched sizes.
- last = out_valid && col==col_end && row==row_end. Accepted last beat -> DONE; out_valid drops next cycle.
- out_ready low: col/row/last/out_valid held stable (no retraction).
- DONE: done=1 for exactly one cycle, out_valid=0 -> IDLE. col/row/lin_cnt hold final values until next start.
- start while busy ignored; blk_w/blk_h changes during RUN ignored (latched copy used).
- reset mid-scan: immediate return to IDLE, all outputs 0, no done pulse.

## Timing
- start sampled at edge k -> out_valid=1 from cycle k+1 with col=row=C0.
- Throughput: one beat per cycle with out_ready held high.
- Last beat accepted at edge m -> done=1 in cycle m+1, busy=0 and new start accepted from cycle m+2.
- Start to done with out_ready=1: N+1 cycles of busy, N = beats (W*H, or (W+7)*(H+7) with margin).
- All outputs registered; no combinational path from out_ready to out_valid.

## Configuration
- HEVC_TAP_MARGIN_EN defined: scan covers the 8-tap filter footprint, columns -3..W+3 and rows -3..H+3 in two's complement; N=(W+7)*(H+7). Margin endpoints must fit signed COORD_W.
- Undefined: scan covers 0..W-1 by 0..H-1 unsigned; N=W*H.

## Structure
- Package hevc_interp_pkg: state enum (IDLE, RUN, DONE), TAP_PRE=3, TAP_POST=4, C0 derived from the macro.
- Sub-module axis_counter: one wrapping counter with load, inc, end value and at_end flag. Instantiated twice: col increments per beat; row increments on col wrap.
- FSM, lin_cnt and last in the top level.

## Test plan
- Reset held, then released: all outputs 0, state IDLE; start during reset has no effect.
- blk_w=4, blk_h=2, out_ready=1 (no margin): beats (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); last on beat 8; done pulse 1 cycle later; lin_cnt=8.
- Same block with out_ready toggling 1,0,1,0: coordinates stable while stalled, same 8-beat sequence, done after 8th accept.
- blk_w=0, blk_h=5: no out_valid; done pulse one cycle after start; lin_cnt=0.
- HEVC_TAP_MARGIN_EN, blk_w=4, blk_h=4: first beat col=row=-3 (8'hFD); last at (7,7); lin_cnt=121.
- Reset asserted mid-scan at beat 3 of 8: outputs 0 next edge, no done; new start rescans from (0,0).
